split_constraint_stream_checker: RTL and testbench
==================================================

// Module: split_constraint_stream_checker
// PURPOSE
//  Streaming, pipelined successor to the single-shot split constraint checkers. Accepts
//  candidate assignments (v7, v17, v24) over valid/ready and evaluates the 5-constraint split.
//  Emits per-candidate verdicts with per-constraint bits. Keeps pass/fail statistics and
//  captures the first satisfying assignment. Sits between the BDD candidate enumerator and
//  the solver result collector.
// PARAMETERS
//  W7      15      width of v7
//  W17     15      width of v17
//  W24     9       width of v24
//  CW      16      arithmetic width for the c13/c20 subtract terms
//  K24     16'h62  constant subtracted from v24 in c13
//  K17     16'h2d49 constant subtracted from v17 in c20
//  SH      12      left-shift amount in c20 (0 <= SH < CW)
//  CNT_W   32      width of the pass/fail counters
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      candidate valid
//  in_ready    out  1      candidate accepted when in_valid & in_ready
//  in_v7       in   W7     candidate v7
//  in_v17      in   W17    candidate v17
//  in_v24      in   W24    candidate v24
//  cfg_mask    in   5      per-constraint enable; 0 = constraint forced true; sampled at accept
//  clear_stats in   1      synchronous clear of counters and first-hit capture
//  out_valid   out  1      verdict valid
//  out_ready   in   1      verdict consumed when out_valid & out_ready
//  out_sat     out  1      AND of all masked constraint bits
//  out_cbits   out  5      {c45,c36,c20,c13,c7} raw (unmasked) constraint bits
//  hit_valid   out  1      a satisfying candidate has been captured
//  hit_v7/hit_v17/hit_v24  out  W7/W17/W24  captured first satisfying candidate
//  pass_cnt    out  CNT_W  number of consumed verdicts with out_sat=1, saturating
//  fail_cnt    out  CNT_W  number of consumed verdicts with out_sat=0, saturating
// BEHAVIOUR
//  Constraints (unsigned; result truncated to the stated width):
//   c7  = ((~v7) + v17) mod 2^max(W7,W17) != 0, i.e. v17 != v7+1 (mod 2^W)
//   c13 = ~((zext(v24) - K24) mod 2^CW) != 0, i.e. false only when v24 == K24-1
//   c20 = (((zext(v17) - K17) mod 2^CW) << SH) mod 2^CW != 0 (only the low CW-SH bits matter)
//   c36 = (v17 != 0) || (v24 != 0)
//   c45 = (v24 == 0)
//   out_sat = &(out_cbits | ~mask_captured)
//  Pipeline: S1 registers the operands and mask; S2 registers the cbits and sat.
//   - S2 advances when !s2_valid || out_ready.
//   - S1 advances when !s1_valid || S2 advances.
//   - in_ready = that S1 advance condition (combinational from out_ready; no in->out comb path).
//   - Latency: accept at cycle N -> out_valid at N+2 under no stall; throughput 1/cycle.
//   - out_* held stable while out_valid & !out_ready.
//  Stats update only on the output handshake: pass_cnt++ if out_sat, else fail_cnt++.
//   Counters stick at 2^CNT_W-1.
//  First hit: on a handshake with out_sat=1 and hit_valid=0, capture the operands carried
//   with the verdict and set hit_valid. Later hits are ignored.
//  clear_stats: the next cycle has counters=0, hit_valid=0 and hit_* unchanged. clear_stats
//   wins over a same-cycle handshake: that beat is neither counted nor captured.
//   Pipeline contents are unaffected.
//  Reset (async, any time, including mid-stream): all valids=0, in_ready=1 after release,
//   out_sat=0, out_cbits=0, counters=0, hit_valid=0, hit_*=0. In-flight candidates are dropped.
// STRUCTURE
//  Package split_constraint_pkg holds:
//   - NUM_C=5
//   - constraint index localparams C7_IDX=0 .. C45_IDX=4
//   - the cbits_t typedef
//  Sub-module split_constraint_eval (purely combinational, same parameters):
//   operands -> cbits. Instantiated between S1 and S2.
//  Top level holds the pipeline regs, handshake logic, counters and hit capture.
// TESTING (defaults, mask=5'h1f)
//  1. v7=0, v17=5, v24=0 -> out_sat=1, cbits=5'h1f at accept+2, pass_cnt=1, hit_valid=1,
//     hit_v17=5.
//  2. v7=0, v17=1, v24=0 -> cbits=5'h1e (c7=0), sat=0, fail_cnt=1. Repeat with mask=5'h1e
//     -> sat=1.
//  3. v17=15'h2d49, v24=0 -> c20=0. v24=9'h61 -> c13=0 and c45=0. v17=0, v24=0 -> c36=0.
//  4. Back-to-back 8 candidates, out_ready low for cycles 3-6: no loss or duplication,
//     order kept, in_ready drops after 2 held, outputs stable while stalled.
//  5. Force pass_cnt to 32'hffffffff then one pass -> stays 32'hffffffff. clear_stats
//     coincident with a passing handshake -> counters 0, hit_valid 0.
//  6. Assert rst with 2 candidates in flight -> out_valid=0 immediately, counters 0;
//     after release the first new candidate emerges 2 cycles after accept.

Source files
------------

// File: rtl/split_constraint_stream_checker_pkg.sv
// Shared constants and types for the split constraint stream checker.
package split_constraint_pkg;
  localparam int unsigned NUM_C   = 5;
  localparam int unsigned C7_IDX  = 0;
  localparam int unsigned C13_IDX = 1;
  localparam int unsigned C20_IDX = 2;
  localparam int unsigned C36_IDX = 3;
  localparam int unsigned C45_IDX = 4;

  typedef logic [NUM_C-1:0] cbits_t;
endpackage

// File: rtl/split_constraint_stream_checker_if.sv
// Candidate-in / verdict-out stream bundle; master drives candidates, slave is the checker.
interface split_constraint_stream_checker_if #(
  parameter int unsigned W7  = 15,
  parameter int unsigned W17 = 15,
  parameter int unsigned W24 = 9
);
  import split_constraint_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [W7-1:0]  in_v7;
  logic [W17-1:0] in_v17;
  logic [W24-1:0] in_v24;
  cbits_t         cfg_mask;
  logic           out_valid;
  logic           out_ready;
  logic           out_sat;
  cbits_t         out_cbits;

  modport master (
    output in_valid, in_v7, in_v17, in_v24, cfg_mask, out_ready,
    input  in_ready, out_valid, out_sat, out_cbits
  );

  modport slave (
    input  in_valid, in_v7, in_v17, in_v24, cfg_mask, out_ready,
    output in_ready, out_valid, out_sat, out_cbits
  );
endinterface

// File: rtl/split_constraint_stream_checker_eval.sv
// Combinational evaluation of the five split constraints for one candidate.
module split_constraint_eval
  import split_constraint_pkg::*;
#(
  parameter int unsigned W7  = 15,
  parameter int unsigned W17 = 15,
  parameter int unsigned W24 = 9,
  parameter int unsigned CW  = 16,
  parameter logic [CW-1:0] K24 = 'h62,
  parameter logic [CW-1:0] K17 = 'h2d49,
  parameter int unsigned SH  = 12
) (
  input  logic [W7-1:0]  v7,
  input  logic [W17-1:0] v17,
  input  logic [W24-1:0] v24,
  output cbits_t         cbits
);
  localparam int unsigned WM = (W7 > W17) ? W7 : W17;

  logic [WM-1:0] sum7;
  logic [CW-1:0] d13;
  logic [CW-1:0] d17;
  logic [CW-1:0] d20;

  always_comb begin
    sum7 = ~WM'(v7) + WM'(v17);
    d13  = CW'(v24) - K24;
    d17  = CW'(v17) - K17;
    // the shift discards the upper SH bits of the difference
    d20  = d17 << SH;
    cbits          = '0;
    cbits[C7_IDX]  = (sum7 != '0);
    cbits[C13_IDX] = (d13 != '1);
    cbits[C20_IDX] = (d20 != '0);
    cbits[C36_IDX] = (v17 != '0) || (v24 != '0);
    cbits[C45_IDX] = (v24 == '0);
  end
endmodule

// File: rtl/split_constraint_stream_checker.sv
// Two-stage valid/ready checker: S1 holds operands+mask, S2 holds the verdict;
// pass/fail statistics and first-hit capture happen on the output handshake.
module split_constraint_stream_checker
  import split_constraint_pkg::*;
#(
  parameter int unsigned W7    = 15,
  parameter int unsigned W17   = 15,
  parameter int unsigned W24   = 9,
  parameter int unsigned CW    = 16,
  parameter logic [CW-1:0] K24 = 'h62,
  parameter logic [CW-1:0] K17 = 'h2d49,
  parameter int unsigned SH    = 12,
  parameter int unsigned CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  split_constraint_stream_checker_if.slave bus,
  input  logic                         clear_stats,
  output logic                         hit_valid,
  output logic [W7-1:0]                hit_v7,
  output logic [W17-1:0]               hit_v17,
  output logic [W24-1:0]               hit_v24,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             fail_cnt
);
  logic           s1_valid, s2_valid;
  logic [W7-1:0]  s1_v7, s2_v7;
  logic [W17-1:0] s1_v17, s2_v17;
  logic [W24-1:0] s1_v24, s2_v24;
  cbits_t         s1_mask;
  cbits_t         s2_cbits;
  logic           s2_sat;
  cbits_t         cbits;
  logic           s1_adv, s2_adv, hs;

  assign s2_adv        = !s2_valid || bus.out_ready;
  assign s1_adv        = !s1_valid || s2_adv;
  assign hs            = s2_valid && bus.out_ready;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_sat   = s2_sat;
  assign bus.out_cbits = s2_cbits;

  split_constraint_eval #(
    .W7(W7), .W17(W17), .W24(W24), .CW(CW), .K24(K24), .K17(K17), .SH(SH)
  ) u_eval (
    .v7(s1_v7), .v17(s1_v17), .v24(s1_v24), .cbits(cbits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_v7    <= '0;
      s1_v17   <= '0;
      s1_v24   <= '0;
      s1_mask  <= '0;
      s2_valid <= 1'b0;
      s2_v7    <= '0;
      s2_v17   <= '0;
      s2_v24   <= '0;
      s2_cbits <= '0;
      s2_sat   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_v7   <= bus.in_v7;
          s1_v17  <= bus.in_v17;
          s1_v24  <= bus.in_v24;
          s1_mask <= bus.cfg_mask;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_v7    <= s1_v7;
          s2_v17   <= s1_v17;
          s2_v24   <= s1_v24;
          s2_cbits <= cbits;
          s2_sat   <= &(cbits | ~s1_mask);
        end
      end
    end
  end

  // clear_stats takes priority: a coincident handshake is neither counted nor captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      hit_valid <= 1'b0;
      hit_v7    <= '0;
      hit_v17   <= '0;
      hit_v24   <= '0;
    end else if (clear_stats) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      hit_valid <= 1'b0;
    end else if (hs) begin
      if (s2_sat) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        if (!hit_valid) begin
          hit_valid <= 1'b1;
          hit_v7    <= s2_v7;
          hit_v17   <= s2_v17;
          hit_v24   <= s2_v24;
        end
      end else if (fail_cnt != '1) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_split_constraint_stream_checker.sv
// Directed, table-driven bench for split_constraint_stream_checker.
module tb_split_constraint_stream_checker;
  typedef struct {
    logic [14:0] v7;
    logic [14:0] v17;
    logic [8:0]  v24;
    logic [4:0]  mask;
    logic [4:0]  cbits;
    logic        sat;
  } vec_t;

  logic clk;
  logic rst;
  logic clear_stats, clear_stats2;
  logic hit_valid, hit_valid2;
  logic [14:0] hit_v7, hit_v17, hit_v72, hit_v172;
  logic [8:0]  hit_v24, hit_v242;
  logic [31:0] pass_cnt, fail_cnt;
  logic [1:0]  pass_cnt2, fail_cnt2;

  int tests = 0;
  int fails = 0;
  int exp_pass = 0;
  int exp_fail = 0;
  logic        exp_hit_valid = 1'b0;
  logic [14:0] exp_hit_v7 = '0;
  logic [14:0] exp_hit_v17 = '0;
  logic [8:0]  exp_hit_v24 = '0;

  vec_t tbl[10];
  vec_t strm[8];
  vec_t vclr;

  split_constraint_stream_checker_if bus ();
  split_constraint_stream_checker_if bus2 ();

  split_constraint_stream_checker dut (
    .clk(clk), .rst(rst), .bus(bus), .clear_stats(clear_stats),
    .hit_valid(hit_valid), .hit_v7(hit_v7), .hit_v17(hit_v17), .hit_v24(hit_v24),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  split_constraint_stream_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .clear_stats(clear_stats2),
    .hit_valid(hit_valid2), .hit_v7(hit_v72), .hit_v17(hit_v172), .hit_v24(hit_v242),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_v7    = v.v7;
    bus.in_v17   = v.v17;
    bus.in_v24   = v.v24;
    bus.cfg_mask = v.mask;
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, "_pass"}, pass_cnt, exp_pass);
    chk({nm, "_fail"}, fail_cnt, exp_fail);
    chk({nm, "_hit_valid"}, {31'b0, hit_valid}, {31'b0, exp_hit_valid});
    if (exp_hit_valid) begin
      chk({nm, "_hit_v7"}, {17'b0, hit_v7}, {17'b0, exp_hit_v7});
      chk({nm, "_hit_v17"}, {17'b0, hit_v17}, {17'b0, exp_hit_v17});
      chk({nm, "_hit_v24"}, {23'b0, hit_v24}, {23'b0, exp_hit_v24});
    end
  endtask

  task automatic model_consume(input vec_t v);
    if (v.sat) exp_pass++;
    else exp_fail++;
    if (v.sat && !exp_hit_valid) begin
      exp_hit_valid = 1'b1;
      exp_hit_v7    = v.v7;
      exp_hit_v17   = v.v17;
      exp_hit_v24   = v.v24;
    end
  endtask

  // entered at posedge+1 with an empty pipeline
  task automatic send_and_check(input vec_t v, input string nm);
    chk({nm, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_early_valid"}, {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({nm, "_cbits"}, {27'b0, bus.out_cbits}, {27'b0, v.cbits});
    chk({nm, "_sat"}, {31'b0, bus.out_sat}, {31'b0, v.sat});
    model_consume(v);
    @(posedge clk); #1;
    chk({nm, "_drained"}, {31'b0, bus.out_valid}, 32'd0);
    chk_stats(nm);
  endtask

  initial begin
    tbl[0] = '{15'h0000, 15'h0005, 9'h000, 5'h1f, 5'h1f, 1'b1};
    tbl[1] = '{15'h0000, 15'h0001, 9'h000, 5'h1f, 5'h1e, 1'b0};
    tbl[2] = '{15'h0000, 15'h0001, 9'h000, 5'h1e, 5'h1e, 1'b1};
    tbl[3] = '{15'h0000, 15'h2d49, 9'h000, 5'h1f, 5'h1b, 1'b0};
    tbl[4] = '{15'h0000, 15'h0005, 9'h061, 5'h1f, 5'h0d, 1'b0};
    tbl[5] = '{15'h0000, 15'h0000, 9'h000, 5'h1f, 5'h17, 1'b0};
    tbl[6] = '{15'h0007, 15'h0008, 9'h001, 5'h0e, 5'h0e, 1'b1};
    tbl[7] = '{15'h7fff, 15'h0000, 9'h1ff, 5'h1f, 5'h0e, 1'b0};
    tbl[8] = '{15'h0001, 15'h2d59, 9'h002, 5'h04, 5'h0b, 1'b0};
    tbl[9] = '{15'h0003, 15'h0004, 9'h061, 5'h00, 5'h0c, 1'b1};

    strm[0] = '{15'h0000, 15'h0005, 9'h000, 5'h1f, 5'h1f, 1'b1};
    strm[1] = '{15'h0000, 15'h0001, 9'h000, 5'h1f, 5'h1e, 1'b0};
    strm[2] = '{15'h0000, 15'h2d49, 9'h000, 5'h1f, 5'h1b, 1'b0};
    strm[3] = '{15'h2d48, 15'h2d49, 9'h000, 5'h1f, 5'h1a, 1'b0};
    strm[4] = '{15'h0000, 15'h0000, 9'h000, 5'h1f, 5'h17, 1'b0};
    strm[5] = '{15'h7fff, 15'h0000, 9'h000, 5'h1f, 5'h16, 1'b0};
    strm[6] = '{15'h0000, 15'h0005, 9'h061, 5'h1f, 5'h0d, 1'b0};
    strm[7] = '{15'h0000, 15'h0005, 9'h001, 5'h1f, 5'h0f, 1'b0};

    vclr = '{15'h0000, 15'h0006, 9'h000, 5'h1f, 5'h1f, 1'b1};

    rst = 1'b1;
    clear_stats = 1'b0;
    clear_stats2 = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(tbl[0]);
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    bus2.in_v7 = '0;
    bus2.in_v17 = 15'h0005;
    bus2.in_v24 = '0;
    bus2.cfg_mask = 5'h1f;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_sat", {31'b0, bus.out_sat}, 32'd0);
    chk("rst_out_cbits", {27'b0, bus.out_cbits}, 32'd0);
    chk("rst_hit_v17", {17'b0, hit_v17}, 32'd0);
    chk_stats("rst");

    for (int unsigned i = 0; i < 10; i++) send_and_check(tbl[i], $sformatf("vec%0d", i));

    // back-to-back stream with out_ready low for cycles 3-6
    begin
      int acc = 0;
      int got = 0;
      int cyc = 0;
      int stall_low = 0;
      logic held = 1'b0;
      logic [4:0] held_cbits = '0;
      logic held_sat = 1'b0;
      while (got < 8 && cyc < 60) begin
        bus.out_ready = !(cyc >= 3 && cyc <= 6);
        if (acc < 8) begin
          bus.in_valid = 1'b1;
          drive(strm[acc]);
        end else begin
          bus.in_valid = 1'b0;
        end
        #1;
        if (held) begin
          chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
          chk("stall_cbits", {27'b0, bus.out_cbits}, {27'b0, held_cbits});
          chk("stall_sat", {31'b0, bus.out_sat}, {31'b0, held_sat});
        end
        if (!bus.out_ready && !bus.in_ready) stall_low++;
        if (bus.out_valid && bus.out_ready) begin
          chk($sformatf("stream_cbits%0d", got), {27'b0, bus.out_cbits}, {27'b0, strm[got].cbits});
          chk($sformatf("stream_sat%0d", got), {31'b0, bus.out_sat}, {31'b0, strm[got].sat});
          model_consume(strm[got]);
          got++;
        end
        held = bus.out_valid && !bus.out_ready;
        held_cbits = bus.out_cbits;
        held_sat = bus.out_sat;
        if (bus.in_valid && bus.in_ready) acc++;
        @(posedge clk); #1;
        cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("stream_count", got, 32'd8);
      chk("stream_accepted", acc, 32'd8);
      chk("stream_inready_low_cycles", stall_low, 32'd4);
      chk_stats("stream");
      repeat (3) @(posedge clk);
      #1;
      chk("stream_no_dup", {31'b0, bus.out_valid}, 32'd0);
    end

    // clear_stats coincident with a passing handshake
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    drive(tbl[0]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("clr_held_valid", {31'b0, bus.out_valid}, 32'd1);
    chk_stats("clr_before");
    bus.out_ready = 1'b1;
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    chk("clr_pass", pass_cnt, 32'd0);
    chk("clr_fail", fail_cnt, 32'd0);
    chk("clr_hit_valid", {31'b0, hit_valid}, 32'd0);
    chk("clr_hit_v17_kept", {17'b0, hit_v17}, {17'b0, exp_hit_v17});
    chk("clr_beat_consumed", {31'b0, bus.out_valid}, 32'd0);
    exp_pass = 0;
    exp_fail = 0;
    exp_hit_valid = 1'b0;
    send_and_check(vclr, "after_clr");

    // counter saturation on the narrow-counter instance
    bus2.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_pass2", {30'b0, pass_cnt2}, 32'd2);
    bus2.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_pass_stuck", {30'b0, pass_cnt2}, 32'd3);
    chk("sat_fail2", {30'b0, fail_cnt2}, 32'd0);

    // reset with two candidates in flight
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    drive(tbl[1]);
    @(posedge clk); #1;
    drive(tbl[3]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("inflight_valid", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_out_cbits", {27'b0, bus.out_cbits}, 32'd0);
    chk("arst_out_sat", {31'b0, bus.out_sat}, 32'd0);
    chk("arst_pass", pass_cnt, 32'd0);
    chk("arst_fail", fail_cnt, 32'd0);
    chk("arst_hit_valid", {31'b0, hit_valid}, 32'd0);
    chk("arst_hit_v17", {17'b0, hit_v17}, 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    exp_hit_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_empty", {31'b0, bus.out_valid}, 32'd0);
    send_and_check(tbl[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
